// File: rtl/div_unit_pkg.sv
// Core package: ALU control encodings, divider op encoding and divider FSM states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package div_unit_pkg;

  localparam int DIV_XLEN = 64;

  // ALU control encodings shared with the execute stage
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_e;

  // bit0 = unsigned, bit1 = remainder, bit2 = 32-bit word op
  typedef enum logic [2:0] {
    DIV_OP_DIV   = 3'b000,
    DIV_OP_DIVU  = 3'b001,
    DIV_OP_REM   = 3'b010,
    DIV_OP_REMU  = 3'b011,
    DIV_OP_DIVW  = 3'b100,
    DIV_OP_DIVUW = 3'b101,
    DIV_OP_REMW  = 3'b110,
    DIV_OP_REMUW = 3'b111
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_FIN  = 2'b10
  } div_state_e;

  function automatic logic op_is_signed(div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(div_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_word(div_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/div_core.sv
// Unsigned restoring shift-subtract divider, one quotient bit per step.
// Latency: n_iter step cycles after load; last is high during the final step.
// Backpressure: none; clear abandons the iteration, reset clears all state.
module div_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic        clear,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  input  logic [6:0]  n_iter,
  output logic [63:0] quot,
  output logic [63:0] rem,
  output logic        last
);

  logic [63:0] quot_q;
  logic [63:0] rem_q;
  logic [63:0] divisor_q;
  logic [6:0]  cnt_q;
  logic [64:0] trial;
  logic [64:0] diff;

  // Shift the next dividend bit into the partial remainder and trial-subtract;
  // diff[64] set means the trial was smaller than the divisor (restore).
  always_comb begin
    trial = {rem_q, quot_q[63]};
    diff  = trial - {1'b0, divisor_q};
  end

  // Operand load, per-step remainder/quotient update and iteration count
  always_ff @(posedge clk) begin
    if (reset) begin
      quot_q    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (load) begin
      quot_q    <= dividend;
      rem_q     <= '0;
      divisor_q <= divisor;
      cnt_q     <= n_iter;
    end else if (step && (cnt_q != 7'd0)) begin
      cnt_q <= cnt_q - 7'd1;
      if (!diff[64]) begin
        rem_q  <= diff[63:0];
        quot_q <= {quot_q[62:0], 1'b1};
      end else begin
        rem_q  <= trial[63:0];
        quot_q <= {quot_q[62:0], 1'b0};
      end
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q;
  assign last = (cnt_q == 7'd1);

endmodule

// File: rtl/div_unit.sv
// Integer divide/remainder unit (64-bit and 32-bit word ops) with special-case bypass.
// Latency: Done N+1 cycles after Start (N=64, or 32 for W ops); 1 cycle for /0 and overflow.
// Backpressure: Start accepted only when idle (Busy=0); Flush aborts with no Done.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic            Flush,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      DivOp,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  div_state_e  state_q, state_n;
  div_op_e     op_in;
  logic        op_w, op_signed, op_rem;
  logic [63:0] a_ext, b_ext, a_mag, b_mag;
  logic        a_neg, b_neg;
  logic        div_zero, overflow, special;
  logic [63:0] special_raw;
  logic [63:0] core_dividend;
  logic        start_acc;

  logic        op_w_q, op_rem_q, q_neg_q, r_neg_q, special_q;
  logic [63:0] special_raw_q;
  logic [63:0] result_q;

  logic [63:0] core_quot, core_rem;
  logic        core_last;
  logic [63:0] quot_s, rem_s, fin_raw, fin_val;

  assign op_in     = div_op_e'(DivOp);
  assign op_w      = op_is_word(op_in);
  assign op_signed = op_is_signed(op_in);
  assign op_rem    = op_is_rem(op_in);

  // Operand extension, magnitudes and special-case detection for the incoming request
  always_comb begin
    if (op_w) begin
      a_ext = op_signed ? {{32{SrcA[31]}}, SrcA[31:0]} : {32'b0, SrcA[31:0]};
      b_ext = op_signed ? {{32{SrcB[31]}}, SrcB[31:0]} : {32'b0, SrcB[31:0]};
    end else begin
      a_ext = SrcA;
      b_ext = SrcB;
    end
    a_neg    = op_signed & a_ext[63];
    b_neg    = op_signed & b_ext[63];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = (b_ext == 64'd0);
    overflow = op_signed & (b_ext == '1) &
               (a_ext == (op_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    special  = div_zero | overflow;
    if (div_zero)
      special_raw = op_rem ? a_ext : '1;
    else
      special_raw = op_rem ? 64'd0 : a_ext;
    // Word ops park the dividend in the top half so the core shifts out bit 31 first
    core_dividend = op_w ? {a_mag[31:0], 32'b0} : a_mag;
  end

  assign start_acc = Start & ~Flush & (state_q == DIV_IDLE);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= DIV_IDLE;
    else       state_q <= state_n;
  end

  // Next-state: specials skip straight to FIN; Flush overrides everything
  always_comb begin
    state_n = state_q;
    case (state_q)
      DIV_IDLE: if (start_acc) state_n = special ? DIV_FIN : DIV_CALC;
      DIV_CALC: if (core_last) state_n = DIV_FIN;
      DIV_FIN:  state_n = DIV_IDLE;
      default:  state_n = DIV_IDLE;
    endcase
    if (Flush) state_n = DIV_IDLE;
  end

  assign Busy = (state_q != DIV_IDLE);
  assign Done = (state_q == DIV_FIN);

  // Capture the per-operation controls needed to post-process the core result
  always_ff @(posedge clk) begin
    if (reset) begin
      op_w_q        <= 1'b0;
      op_rem_q      <= 1'b0;
      q_neg_q       <= 1'b0;
      r_neg_q       <= 1'b0;
      special_q     <= 1'b0;
      special_raw_q <= '0;
    end else if (start_acc) begin
      op_w_q        <= op_w;
      op_rem_q      <= op_rem;
      q_neg_q       <= a_neg ^ b_neg;
      r_neg_q       <= a_neg;
      special_q     <= special;
      special_raw_q <= special_raw;
    end
  end

  div_core u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (start_acc & ~special),
    .step     (state_q == DIV_CALC),
    .clear    (Flush),
    .dividend (core_dividend),
    .divisor  (b_mag),
    .n_iter   (op_w ? 7'd32 : 7'd64),
    .quot     (core_quot),
    .rem      (core_rem),
    .last     (core_last)
  );

  // Sign correction, special-case select and word sign-extension of the final value
  always_comb begin
    quot_s  = q_neg_q ? -core_quot : core_quot;
    rem_s   = r_neg_q ? -core_rem : core_rem;
    fin_raw = special_q ? special_raw_q : (op_rem_q ? rem_s : quot_s);
    fin_val = op_w_q ? {{32{fin_raw[31]}}, fin_raw[31:0]} : fin_raw;
  end

  // Hold the delivered result until the next operation completes
  always_ff @(posedge clk) begin
    if (reset)                    result_q <= '0;
    else if (state_q == DIV_FIN)  result_q <= fin_val;
  end

  assign Result = Done ? fin_val : result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus flush/reset/busy sequences.
// Latency: Done cycle counted from the Start cycle (cycle 0).
// Backpressure: every wait on Done is bounded.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic        Flush;
  logic [63:0] SrcA;
  logic [63:0] SrcB;
  logic [2:0]  DivOp;
  logic        Busy;
  logic        Done;
  logic [63:0] Result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[20];

  div_unit #(.XLEN(64)) dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .Flush  (Flush),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .DivOp  (DivOp),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Call at a negedge (cycle 0); returns just after the accepting edge (cycle 1)
  task automatic start_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    Start = 1'b1;
    DivOp = op;
    SrcA  = a;
    SrcB  = b;
    @(posedge clk);
    #1 Start = 1'b0;
  endtask

  // Count cycles from 1 until Done, sampling at negedges
  task automatic wait_done(input string name, input logic [63:0] exp, input int exp_cyc);
    int cyc = 1;
    bit seen = 1'b0;
    while (!seen && cyc <= 100) begin
      @(negedge clk);
      if (cyc == 1) chk({name, " busy"}, 64'(Busy), 64'd1);
      if (Done) seen = 1'b1;
      else cyc++;
    end
    chk({name, " done_cycle"}, 64'(cyc), 64'(exp_cyc));
    chk({name, " result"}, Result, exp);
  endtask

  task automatic run_op(input vec_t v);
    @(negedge clk);
    start_op(v.op, v.a, v.b);
    wait_done(v.name, v.exp, v.lat);
  endtask

  initial begin
    bit done_seen;

    vecs[0]  = '{"divu_100_7",   3'b001, 64'd100, 64'd7, 64'd14, 65};
    vecs[1]  = '{"remu_100_7",   3'b011, 64'd100, 64'd7, 64'd2, 65};
    vecs[2]  = '{"rem_m7_2",     3'b010, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[3]  = '{"div_m7_2",     3'b000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[4]  = '{"div_5_0",      3'b000, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[5]  = '{"remu_5_0",     3'b011, 64'd5, 64'd0, 64'd5, 1};
    vecs[6]  = '{"div_ovf",      3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    vecs[7]  = '{"rem_ovf",      3'b010, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    vecs[8]  = '{"divw_ovf",     3'b100, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[9]  = '{"remw_ovf",     3'b110, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1};
    vecs[10] = '{"divuw_fffe_1", 3'b101, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    vecs[11] = '{"remw_m7_2",    3'b110, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[12] = '{"divuw_by0",    3'b101, 64'h0000_0000_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[13] = '{"remuw_by0",    3'b111, 64'h0000_0000_8000_0003, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_8000_0003, 1};
    vecs[14] = '{"divu_max_1",   3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[15] = '{"remu_max_16",  3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 65};
    vecs[16] = '{"div_20_m3",    3'b000, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA, 65};
    vecs[17] = '{"divw_100_m7",  3'b100, 64'd100, 64'h0000_0000_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 33};
    vecs[18] = '{"divuw_big_2",  3'b101, 64'h0000_0000_8000_0000, 64'd2, 64'h0000_0000_4000_0000, 33};
    vecs[19] = '{"rem_7_m2",     3'b010, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65};

    reset = 1'b1;
    Start = 1'b0;
    Flush = 1'b0;
    SrcA  = '0;
    SrcB  = '0;
    DivOp = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset busy",   64'(Busy), 64'd0);
    chk("reset done",   64'(Done), 64'd0);
    chk("reset result", Result,    64'd0);

    // Table vectors, issued back to back (each Start in the cycle after FIN)
    for (int i = 0; i < 20; i++) run_op(vecs[i]);

    // Result holds after Done
    repeat (3) @(negedge clk);
    chk("hold done",   64'(Done), 64'd0);
    chk("hold busy",   64'(Busy), 64'd0);
    chk("hold result", Result,    64'd1);

    // Start while busy is ignored; latched operands are unaffected
    @(negedge clk);
    start_op(3'b001, 64'd100, 64'd7);
    repeat (4) @(negedge clk);
    Start = 1'b1; DivOp = 3'b000; SrcA = 64'd5; SrcB = 64'd0;
    @(posedge clk);
    #1 Start = 1'b0;
    wait_done("ignore_start", 64'd14, 61);

    // Flush at cycle 10, restart at cycle 11
    @(negedge clk);
    start_op(3'b001, 64'd100, 64'd7);
    done_seen = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      done_seen = done_seen | Done;
    end
    Flush = 1'b1;
    @(posedge clk);
    #1 Flush = 1'b0;
    @(negedge clk);
    chk("flush no_done_before", 64'(done_seen), 64'd0);
    chk("flush busy", 64'(Busy), 64'd0);
    chk("flush done", 64'(Done), 64'd0);
    start_op(3'b011, 64'd100, 64'd7);
    wait_done("flush_restart", 64'd2, 65);

    // Start and Flush together: Start dropped
    @(negedge clk);
    Start = 1'b1; Flush = 1'b1; DivOp = 3'b001; SrcA = 64'd100; SrcB = 64'd7;
    @(posedge clk);
    #1 begin Start = 1'b0; Flush = 1'b0; end
    @(negedge clk);
    chk("start_flush busy",   64'(Busy), 64'd0);
    chk("start_flush result", Result,    64'd2);

    // Reset at cycle 20 of an operation
    @(negedge clk);
    start_op(3'b001, 64'd100, 64'd7);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midreset busy",   64'(Busy), 64'd0);
    chk("midreset done",   64'(Done), 64'd0);
    chk("midreset result", Result,    64'd0);
    start_op(3'b001, 64'd1000, 64'd10);
    wait_done("reset_restart", 64'd100, 65);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
